// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer arbiter: FSM state encoding,
// default address/data widths and the 640x480 frame size.
package fb_pkg;

  localparam int FB_ADDR_W      = 19;
  localparam int FB_DATA_W      = 16;
  localparam int FB_FRAME_WORDS = 640 * 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2,
    WR_CMD  = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one memory port between the display read stream
// and the camera write stream, one transaction in flight at a time.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W        = FB_ADDR_W,
  parameter int DATA_W        = FB_DATA_W,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  fb_state_e           state_r;
  fb_state_e           state_nxt_s;
  logic [STREAK_W-1:0] streak_r;
  logic [STREAK_W-1:0] streak_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_valid_r;
  logic                rd_grant_s;
  logic                wr_grant_s;
  logic                rd_capture_s;

  // Arbitration: reads win unless a write has waited through a full read streak.
  always_comb begin
    rd_grant_s = 1'b0;
    wr_grant_s = 1'b0;
    if (state_r == IDLE) begin
      if (i_rd_req && (!i_wr_req || (streak_r < STREAK_MAX))) begin
        rd_grant_s = 1'b1;
      end else if (i_wr_req) begin
        wr_grant_s = 1'b1;
      end else begin
        rd_grant_s = 1'b0;
      end
    end else begin
      wr_grant_s = 1'b0;
    end
  end

  // Next-state and streak-counter logic.
  always_comb begin
    state_nxt_s  = state_r;
    streak_nxt_s = streak_r;
    case (state_r)
      IDLE: begin
        if (rd_grant_s) begin
          state_nxt_s = RD_CMD;
        end else if (wr_grant_s) begin
          state_nxt_s = WR_CMD;
        end else begin
          state_nxt_s = IDLE;
        end
        if (wr_grant_s || !i_wr_req) begin
          streak_nxt_s = '0;
        end else if (rd_grant_s && (streak_r != STREAK_MAX)) begin
          streak_nxt_s = streak_r + STREAK_ONE;
        end else begin
          streak_nxt_s = streak_r;
        end
      end
      RD_CMD:  state_nxt_s = i_mem_ready  ? RD_DATA : RD_CMD;
      RD_DATA: state_nxt_s = i_mem_rvalid ? IDLE    : RD_DATA;
      WR_CMD:  state_nxt_s = i_mem_ready  ? IDLE    : WR_CMD;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and streak registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r  <= IDLE;
      streak_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      streak_r <= streak_nxt_s;
    end
  end

  // Command payload is captured at grant and held untouched until the next grant.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (rd_grant_s) begin
      mem_addr_r  <= i_rd_addr;
    end else if (wr_grant_s) begin
      mem_addr_r  <= i_wr_addr;
      mem_wdata_r <= i_wr_data;
    end
  end

  assign rd_capture_s = (state_r == RD_DATA) && i_mem_rvalid;

  // Read return: one-cycle valid pulse, data held between pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_capture_s;
      if (rd_capture_s) begin
        rd_data_r <= i_mem_rdata;
      end
    end
  end

  assign o_mem_req   = (state_r == RD_CMD) || (state_r == WR_CMD);
  assign o_mem_we    = (state_r == WR_CMD);
  assign o_mem_addr  = mem_addr_r;
  assign o_mem_wdata = mem_wdata_r;
  assign o_rd_ack    = (state_r == RD_CMD) && i_mem_ready;
  assign o_wr_ack    = (state_r == WR_CMD) && i_mem_ready;
  assign o_rd_valid  = rd_valid_r;
  assign o_rd_data   = rd_data_r;
  assign o_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a scoreboard of expected grants and read data.
module tb_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req, mem_ready, mem_rvalid;
  logic [AW-1:0] rd_addr, wr_addr, mem_addr;
  logic [DW-1:0] wr_data, mem_rdata, rd_data, mem_wdata;
  logic          rd_ack, rd_valid, wr_ack, mem_req, mem_we, busy;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  grant_t        grant_q[$];
  logic [DW-1:0] rdq[$];
  int            checks = 0;
  int            errors = 0;
  int            ack_count = 0;

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_STREAK(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted command and every read-data pulse is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_ack || wr_ack) begin
        grant_t g;
        ack_count++;
        check("ack_expected", 32'(grant_q.size() != 0), 32'd1);
        if (grant_q.size() != 0) begin
          g = grant_q.pop_front();
          check("grant_we", 32'(mem_we), 32'(g.we));
          check("grant_rd_ack", 32'(rd_ack), 32'(!g.we));
          check("grant_addr", 32'(mem_addr), 32'(g.addr));
          if (g.we) check("grant_wdata", 32'(mem_wdata), 32'(g.wdata));
        end
      end
      if (rd_valid) begin
        check("rd_valid_expected", 32'(rdq.size() != 0), 32'd1);
        if (rdq.size() != 0) check("rd_data", 32'(rd_data), 32'(rdq.pop_front()));
      end
    end
  end

  initial begin
    int base;
    int cyc;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Read only, memory ready at once.
    tick();
    rd_req = 1'b1; rd_addr = 19'h00010; mem_ready = 1'b1;
    grant_q.push_back('{we: 1'b0, addr: 19'h00010, wdata: 16'h0000});
    @(negedge clk);
    check("rd_req_latency_idle", 32'(mem_req), 32'd0);
    tick();
    @(negedge clk);
    check("rd_cmd_mem_req", 32'(mem_req), 32'd1);
    check("rd_cmd_ack", 32'(rd_ack), 32'd1);
    check("rd_cmd_we", 32'(mem_we), 32'd0);
    tick();
    rd_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hF800;
    rdq.push_back(16'hF800);
    @(negedge clk);
    check("rd_data_busy", 32'(busy), 32'd1);
    check("rd_data_no_req", 32'(mem_req), 32'd0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    check("rd_valid_pulse", 32'(rd_valid), 32'd1);
    check("rd_back_idle", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    check("rd_valid_one_cycle", 32'(rd_valid), 32'd0);
    check("rd_data_hold", 32'(rd_data), 32'hF800);

    // Write only, memory ready delayed 3 cycles.
    tick();
    wr_req = 1'b1; wr_addr = 19'h4AFFF; wr_data = 16'h07E0;
    grant_q.push_back('{we: 1'b1, addr: 19'h4AFFF, wdata: 16'h07E0});
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wr_wait_req", 32'(mem_req), 32'd1);
      check("wr_wait_we", 32'(mem_we), 32'd1);
      check("wr_wait_addr", 32'(mem_addr), 32'h4AFFF);
      check("wr_wait_wdata", 32'(mem_wdata), 32'h07E0);
      check("wr_wait_no_ack", 32'(wr_ack), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("wr_ack_pulse", 32'(wr_ack), 32'd1);
    tick();
    wr_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("wr_done_idle", 32'(busy), 32'd0);
    check("wr_done_we_low", 32'(mem_we), 32'd0);

    // Stray rvalid in IDLE, then in RD_CMD.
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    check("stray_idle_busy", 32'(busy), 32'd0);
    tick();
    rd_req = 1'b1; rd_addr = 19'h00123;
    grant_q.push_back('{we: 1'b0, addr: 19'h00123, wdata: 16'h0000});
    @(negedge clk);
    check("stray_idle_no_valid", 32'(rd_valid), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stray_rdcmd_req", 32'(mem_req), 32'd1);
      check("stray_rdcmd_no_valid", 32'(rd_valid), 32'd0);
      tick();
    end
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    tick();
    rd_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hABCD;
    rdq.push_back(16'hABCD);
    tick();
    mem_rvalid = 1'b0;
    tick(); tick();

    // Contention: both requesters held, memory always ready and returning data.
    base = ack_count;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) begin
        grant_q.push_back('{we: 1'b1, addr: 19'h00300, wdata: 16'h001F});
      end else begin
        grant_q.push_back('{we: 1'b0, addr: 19'h00200, wdata: 16'h0000});
        rdq.push_back(16'h1234);
      end
    end
    rd_req = 1'b1; rd_addr = 19'h00200;
    wr_req = 1'b1; wr_addr = 19'h00300; wr_data = 16'h001F;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    cyc = 0;
    while ((ack_count < base + 10) && (cyc < 200)) begin
      tick();
      cyc++;
    end
    check("contention_timeout", 32'(ack_count - base >= 10), 32'd1);
    rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick(); tick();
    check("contention_grants_left", 32'(grant_q.size()), 32'd0);
    check("contention_reads_left", 32'(rdq.size()), 32'd0);

    // Reset while waiting for read data; late rvalid must be ignored.
    rd_req = 1'b1; rd_addr = 19'h00777; mem_ready = 1'b1;
    grant_q.push_back('{we: 1'b0, addr: 19'h00777, wdata: 16'h0000});
    tick(); tick();
    rd_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h5555;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("late_rvalid_no_valid", 32'(rd_valid), 32'd0);
      check("late_rvalid_idle", 32'(busy), 32'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    check("late_rvalid_rd_data", 32'(rd_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, frame-buffer word address width (640x480 pixels).
REQ-002 SHALL have parameter DATA_W, default 16, RGB565 pixel width.
REQ-003 SHALL have parameter MAX_RD_STREAK, default 4, maximum consecutive read grants while a write is pending.
REQ-004 SHALL have ports, in order:
- i_clk  in  1  single clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rd_req  in  1  display read request; held with i_rd_addr until o_rd_ack.
- i_rd_addr  in  ADDR_W  display read address.
- o_rd_ack  out  1  read command accepted.
- o_rd_valid  out  1  read data valid, one-cycle pulse.
- o_rd_data  out  DATA_W  read pixel.
- i_wr_req  in  1  camera write request; held with address/data until o_wr_ack.
- i_wr_addr  in  ADDR_W  write address.
- i_wr_data  in  DATA_W  write pixel.
- o_wr_ack  out  1  write command accepted.
- o_mem_req  out  1  memory command valid.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_ready  in  1  memory accepts command when high with o_mem_req.
- i_mem_rvalid  in  1  memory read data valid.
- i_mem_rdata  in  DATA_W  memory read data.
- o_busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, RD_CMD, RD_DATA, WR_CMD; one memory transaction outstanding at most.
REQ-006 In IDLE, read SHALL win when i_rd_req=1 and (i_wr_req=0 or streak < MAX_RD_STREAK); otherwise write SHALL win when i_wr_req=1; neither -> stay IDLE.
REQ-007 On grant, SHALL register address (and write data, we) and enter RD_CMD/WR_CMD next cycle with o_mem_req=1; grant-to-o_mem_req latency exactly 1 cycle.
REQ-008 o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata SHALL be held stable in RD_CMD/WR_CMD until i_mem_ready=1.
REQ-009 o_rd_ack SHALL equal (state==RD_CMD && i_mem_ready); o_wr_ack SHALL equal (state==WR_CMD && i_mem_ready); combinational, single cycle.
REQ-010 RD_CMD with i_mem_ready -> RD_DATA; WR_CMD with i_mem_ready -> IDLE.
REQ-011 In RD_DATA, i_mem_rvalid=1 SHALL register i_mem_rdata into o_rd_data, pulse o_rd_valid next cycle, and return to IDLE.
REQ-012 o_rd_data SHALL hold its last value when o_rd_valid=0.
REQ-013 i_mem_rvalid outside RD_DATA SHALL be ignored (no o_rd_valid, no state change).
REQ-014 Streak counter (width clog2(MAX_RD_STREAK+1)) SHALL increment on a read grant while i_wr_req=1, saturating at MAX_RD_STREAK; clear on write grant or on any IDLE cycle with i_wr_req=0.
REQ-015 i_mem_ready in IDLE or RD_DATA SHALL have no effect.
REQ-016 Back-to-back: from IDLE after WR_CMD/RD_DATA exit, a new grant SHALL be possible on the first IDLE cycle (2-cycle minimum turnaround per write).
REQ-017 o_mem_we SHALL be 0 outside WR_CMD; o_busy SHALL be combinational from state.

Reset
REQ-018 i_reset=1 SHALL asynchronously force IDLE, streak=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rd_valid=0, o_rd_data=0; o_rd_ack=o_wr_ack=o_busy=0 follow.
REQ-019 Reset mid-transaction SHALL abandon it; late i_mem_rvalid after reset release SHALL be ignored per REQ-013.

Structure
REQ-020 Shared package fb_pkg SHALL hold the state enum type, ADDR_W/DATA_W defaults and frame size constant 640*480.
REQ-021 Single module, no sub-module; streak counter and FSM inline.

Verification
REQ-022 Read only: rd_req addr=0x00010, mem_ready=1 at once, rvalid+rdata=0xF800 two cycles later -> o_mem_req 1 cycle after req, o_rd_ack pulse, o_rd_valid with 0xF800 one cycle after rvalid.
REQ-023 Write only: wr_req addr=0x4AFFF data=0x07E0, mem_ready delayed 3 cycles -> o_mem_we=1, address/data stable for all 4 cycles, single o_wr_ack.
REQ-024 Contention: rd_req and wr_req held continuously, MAX_RD_STREAK=4 -> grant order R,R,R,R,W,R,R,R,R,W.
REQ-025 Stray rvalid=1 in IDLE and in RD_CMD -> no o_rd_valid, state unchanged.
REQ-026 Assert i_reset in RD_DATA, then rvalid after release -> all outputs 0, state IDLE, no o_rd_valid.
